// File: rtl/regfile_writeback_pkg.sv
// Shared constants, issue-select encoding and helpers for the register-file writeback block.
package regfile_writeback_pkg;

    localparam int WORD_SIZE    = 31;
    localparam int REG_IDX_W    = 5;
    localparam int LQ_DEPTH_DEF = 4;
    localparam int DW_DEF       = WORD_SIZE + 1;
    localparam int NUM_REGS     = 1 << REG_IDX_W;

    typedef enum logic [1:0] {
        ISS_NONE = 2'd0,
        ISS_ALU  = 2'd1,
        ISS_LQ   = 2'd2
    } issue_sel_e;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] rd);
        rd_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
    endfunction

endpackage

// File: rtl/wb_load_queue.sv
// Synchronous FIFO of {rd, data} load returns; wrap-bit pointers, per-entry valid/rd for hazard masks.
module wb_load_queue
    import regfile_writeback_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = LQ_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic [REG_IDX_W-1:0]               push_rd,
    input  logic [DW-1:0]                      push_data,
    input  logic                               pop,
    output logic                               full,
    output logic                               empty,
    output logic [REG_IDX_W-1:0]               head_rd,
    output logic [DW-1:0]                      head_data,
    output logic [DEPTH-1:0]                   entry_valid,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]    entry_rd
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]                         wr_ptr_q, wr_ptr_d;
    logic [PW:0]                         rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][REG_IDX_W-1:0]     rd_mem_q, rd_mem_d;
    logic [DEPTH-1:0][DW-1:0]            data_mem_q, data_mem_d;
    logic [PW:0]                         count;
    logic [DEPTH-1:0][PW-1:0]            offs;
    logic                                push_ok;
    logic                                pop_ok;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_rd   = rd_mem_q[rd_ptr_q[PW-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[PW-1:0]];
    assign entry_rd  = rd_mem_q;

    // Slot i holds live data when its distance from the read pointer is below the fill count.
    always_comb begin
        offs        = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs[i]        = PW'(i) - rd_ptr_q[PW-1:0];
            entry_valid[i] = ({1'b0, offs[i]} < count);
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push_ok) begin
            rd_mem_d[wr_ptr_q[PW-1:0]]   = push_rd;
            data_mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d                     = wr_ptr_q + (PW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_mem_q   <= '0;
            data_mem_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU results and queued LSU load returns into one registered regfile write per cycle.
// Define WB_BYPASS_EN to forward the in-flight write onto the decode read data.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_alu_valid,
    input  logic [REG_IDX_W-1:0]  i_alu_rd,
    input  logic [DW-1:0]         i_alu_data,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic [REG_IDX_W-1:0]  i_lsu_rd,
    input  logic [DW-1:0]         i_lsu_data,
    output logic                  o_Wen,
    output logic [REG_IDX_W-1:0]  o_Wnum,
    output logic [DW-1:0]         o_Wd,
    output logic [NUM_REGS-1:0]   o_pend,
    input  logic [REG_IDX_W-1:0]  i_Rnum1,
    input  logic [REG_IDX_W-1:0]  i_Rnum2,
    input  logic [DW-1:0]         i_Rd1,
    input  logic [DW-1:0]         i_Rd2,
    output logic [DW-1:0]         o_Rd1,
    output logic [DW-1:0]         o_Rd2
);

    logic                                 lq_full;
    logic                                 lq_empty;
    logic                                 lq_pop;
    logic [REG_IDX_W-1:0]                 lq_head_rd;
    logic [DW-1:0]                        lq_head_data;
    logic [LQ_DEPTH-1:0]                  lq_valid;
    logic [LQ_DEPTH-1:0][REG_IDX_W-1:0]   lq_rd;

    issue_sel_e                           issue_sel;
    logic [REG_IDX_W-1:0]                 issue_rd;
    logic [DW-1:0]                        issue_data;

    logic                                 wen_q, wen_d;
    logic [REG_IDX_W-1:0]                 wnum_q, wnum_d;
    logic [DW-1:0]                        wd_q, wd_d;

    wb_load_queue #(
        .DW    (DW),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .push        (i_lsu_valid),
        .push_rd     (i_lsu_rd),
        .push_data   (i_lsu_data),
        .pop         (lq_pop),
        .full        (lq_full),
        .empty       (lq_empty),
        .head_rd     (lq_head_rd),
        .head_data   (lq_head_data),
        .entry_valid (lq_valid),
        .entry_rd    (lq_rd)
    );

    // Ready ignores any same-cycle pop so it never depends on the ALU valid.
    assign o_lsu_ready = !lq_full;

    // ALU has fixed priority; the queue drains only in ALU bubbles.
    always_comb begin
        issue_sel  = ISS_NONE;
        issue_rd   = '0;
        issue_data = '0;
        if (i_alu_valid) begin
            issue_sel  = ISS_ALU;
            issue_rd   = i_alu_rd;
            issue_data = i_alu_data;
        end else if (!lq_empty) begin
            issue_sel  = ISS_LQ;
            issue_rd   = lq_head_rd;
            issue_data = lq_head_data;
        end
    end

    assign lq_pop = (issue_sel == ISS_LQ);

    always_comb begin
        wen_d  = 1'b0;
        wnum_d = wnum_q;
        wd_d   = wd_q;
        if (issue_sel != ISS_NONE) begin
            wen_d  = (issue_rd != '0);
            wnum_d = issue_rd;
            wd_d   = issue_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wen_q  <= 1'b0;
            wnum_q <= '0;
            wd_q   <= '0;
        end else begin
            wen_q  <= wen_d;
            wnum_q <= wnum_d;
            wd_q   <= wd_d;
        end
    end

    assign o_Wen  = wen_q;
    assign o_Wnum = wnum_q;
    assign o_Wd   = wd_q;

    always_comb begin
        o_pend = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_valid[i]) begin
                o_pend = o_pend | rd_onehot(lq_rd[i]);
            end
        end
        o_pend[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // The regfile returns the old value when read and written in the same cycle.
    assign o_Rd1 = (wen_q && (wnum_q == i_Rnum1) && (i_Rnum1 != '0)) ? wd_q : i_Rd1;
    assign o_Rd2 = (wen_q && (wnum_q == i_Rnum2) && (i_Rnum2 != '0)) ? wd_q : i_Rd2;
`else
    logic unused_rnum;
    assign unused_rnum = ^{i_Rnum1, i_Rnum2};
    assign o_Rd1 = i_Rd1;
    assign o_Rd2 = i_Rd2;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback: ALU path, contention, full queue, wrap, bypass, reset.
module tb_regfile_writeback;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_lsu_valid;
    logic        o_lsu_ready;
    logic [4:0]  i_lsu_rd;
    logic [31:0] i_lsu_data;
    logic        o_Wen;
    logic [4:0]  o_Wnum;
    logic [31:0] o_Wd;
    logic [31:0] o_pend;
    logic [4:0]  i_Rnum1;
    logic [4:0]  i_Rnum2;
    logic [31:0] i_Rd1;
    logic [31:0] i_Rd2;
    logic [31:0] o_Rd1;
    logic [31:0] o_Rd2;

    int total;
    int bad;

    regfile_writeback dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_alu_valid (i_alu_valid),
        .i_alu_rd    (i_alu_rd),
        .i_alu_data  (i_alu_data),
        .i_lsu_valid (i_lsu_valid),
        .o_lsu_ready (o_lsu_ready),
        .i_lsu_rd    (i_lsu_rd),
        .i_lsu_data  (i_lsu_data),
        .o_Wen       (o_Wen),
        .o_Wnum      (o_Wnum),
        .o_Wd        (o_Wd),
        .o_pend      (o_pend),
        .i_Rnum1     (i_Rnum1),
        .i_Rnum2     (i_Rnum2),
        .i_Rd1       (i_Rd1),
        .i_Rd2       (i_Rd2),
        .o_Rd1       (o_Rd1),
        .o_Rd2       (o_Rd2)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
        i_alu_valid = av;
        i_alu_rd    = ard;
        i_alu_data  = adata;
        i_lsu_valid = lv;
        i_lsu_rd    = lrd;
        i_lsu_data  = ldata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        int pushed;
        int got;
        logic accept;
        logic [31:0] byp_exp;

        total = 0;
        bad   = 0;
        i_rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        i_Rnum1 = 5'd0;
        i_Rnum2 = 5'd0;
        i_Rd1   = 32'h0;
        i_Rd2   = 32'h0;

        #12;
        checkOutput("rst_wen", {31'b0, o_Wen}, 32'h0);
        checkOutput("rst_wnum", {27'b0, o_Wnum}, 32'h0);
        checkOutput("rst_wd", o_Wd, 32'h0);
        checkOutput("rst_pend", o_pend, 32'h0);
        checkOutput("rst_ready", {31'b0, o_lsu_ready}, 32'h1);
        i_rst_n = 1'b1;
        tick();

        $display("[TB] ALU only");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("alu_wen", {31'b0, o_Wen}, 32'h1);
        checkOutput("alu_wnum", {27'b0, o_Wnum}, 32'd5);
        checkOutput("alu_wd", o_Wd, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("alu_x0_wen", {31'b0, o_Wen}, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("idle_wen", {31'b0, o_Wen}, 32'h0);

        $display("[TB] contention");
        applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b1, 5'd7, 32'h00000077);
        tick();
        checkOutput("cont_wnum_a", {27'b0, o_Wnum}, 32'd3);
        checkOutput("cont_wd_a", o_Wd, 32'h33);
        checkOutput("cont_pend_a", o_pend, 32'h00000080);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("cont_wen_b", {31'b0, o_Wen}, 32'h1);
        checkOutput("cont_wnum_b", {27'b0, o_Wnum}, 32'd7);
        checkOutput("cont_wd_b", o_Wd, 32'h77);
        checkOutput("cont_pend_b", o_pend, 32'h0);
        tick();
        checkOutput("cont_idle", {31'b0, o_Wen}, 32'h0);

        $display("[TB] full queue");
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("full_ready_pre%0d", k), {31'b0, o_lsu_ready}, 32'h1);
            applyStimulus(1'b1, 5'd10, 32'h100 + k, 1'b1, 5'(k), 32'hB0 + k);
            tick();
        end
        checkOutput("full_ready", {31'b0, o_lsu_ready}, 32'h0);
        checkOutput("full_pend", o_pend, 32'h0000001E);
        checkOutput("full_alu_wnum", {27'b0, o_Wnum}, 32'd10);
        applyStimulus(1'b1, 5'd10, 32'h200, 1'b1, 5'd5, 32'hB5);
        tick();
        checkOutput("full_hold_ready", {31'b0, o_lsu_ready}, 32'h0);
        checkOutput("full_hold_pend", o_pend, 32'h0000001E);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("drain_wen%0d", k), {31'b0, o_Wen}, 32'h1);
            checkOutput($sformatf("drain_wnum%0d", k), {27'b0, o_Wnum}, k);
            checkOutput($sformatf("drain_wd%0d", k), o_Wd, 32'hB0 + k);
            checkOutput($sformatf("drain_ready%0d", k), {31'b0, o_lsu_ready}, 32'h1);
        end
        checkOutput("drain_pend", o_pend, 32'h0);
        tick();
        checkOutput("drain_idle", {31'b0, o_Wen}, 32'h0);

        $display("[TB] wrap");
        pushed = 0;
        got    = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            applyStimulus((cyc % 3) == 1, 5'd0, $urandom, pushed < 10,
                          5'(11 + pushed), 32'hA0000000 + pushed);
            accept = i_lsu_valid && o_lsu_ready;
            tick();
            if (accept) pushed++;
            if (o_Wen) begin
                checkOutput($sformatf("wrap_wnum%0d", got), {27'b0, o_Wnum}, 11 + got);
                checkOutput($sformatf("wrap_wd%0d", got), o_Wd, 32'hA0000000 + got);
                got++;
            end
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("wrap_count", got, 32'd10);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("wrap_nodup%0d", k), {31'b0, o_Wen}, 32'h0);
        end

        $display("[TB] bypass");
`ifdef WB_BYPASS_EN
        byp_exp = 32'h55;
`else
        byp_exp = 32'h11;
`endif
        applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        i_Rnum1 = 5'd9;
        i_Rd1   = 32'h11;
        i_Rnum2 = 5'd8;
        i_Rd2   = 32'h22;
        #1;
        checkOutput("byp_rd1_hit", o_Rd1, byp_exp);
        checkOutput("byp_rd2_miss", o_Rd2, 32'h22);
        i_Rnum1 = 5'd0;
        i_Rnum2 = 5'd9;
        #1;
        checkOutput("byp_rd1_x0", o_Rd1, 32'h11);
`ifdef WB_BYPASS_EN
        checkOutput("byp_rd2_hit", o_Rd2, 32'h55);
`else
        checkOutput("byp_rd2_hit", o_Rd2, 32'h22);
`endif
        tick();

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 5'd23, 32'hC3, 1'b1, 5'd21, 32'hD1);
        tick();
        applyStimulus(1'b1, 5'd23, 32'hC3, 1'b1, 5'd22, 32'hD2);
        tick();
        checkOutput("pre_rst_wen", {31'b0, o_Wen}, 32'h1);
        checkOutput("pre_rst_pend", o_pend, 32'h00600000);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_wen", {31'b0, o_Wen}, 32'h0);
        checkOutput("mid_rst_wnum", {27'b0, o_Wnum}, 32'h0);
        checkOutput("mid_rst_pend", o_pend, 32'h0);
        checkOutput("mid_rst_ready", {31'b0, o_lsu_ready}, 32'h1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("post_rst_wen%0d", k), {31'b0, o_Wen}, 32'h0);
            checkOutput($sformatf("post_rst_pend%0d", k), o_pend, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
